uart_tx_feeder: RTL and testbench

- Byte FIFO plus launch FSM that sits directly upstream of the UART transmitter.
- Accepts bytes from the trace/host datapath over a valid/ready handshake and buffers them.
- Presents them one at a time on the UART's transmit/tx_byte/tx_free interface, so producers never need to watch UART timing.
- Guarantees exactly one transmit pulse per buffered byte.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_feeder_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_feeder.sv | 97 +++++++++
 tb/tb_uart_tx_feeder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                        |
// | Purpose  : Shared constants and launch-FSM state encoding for the UART     |
// |            transmit feeder.                                                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] F_IDLE      = 2'b00;
    localparam logic [1:0] F_LAUNCH    = 2'b01;
    localparam logic [1:0] F_WAIT_BUSY = 2'b10;
    localparam logic [1:0] F_WAIT_FREE = 2'b11;

endpackage
`default_nettype wire

// File: rtl/uart_tx_feeder_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_fifo                                                       |
// | Purpose  : Single-clock FIFO with wrap-bit pointers, flush and level.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Flush takes priority: it discards both a same-cycle push and pop.
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign level = r_wr_ptr - r_rd_ptr;
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_feeder                                                  |
// | Purpose  : Buffers bytes and launches them one at a time into the UART.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              uart_transmit,
    output logic [BYTE_W-1:0] uart_tx_byte,
    input  logic              uart_tx_free,
    output logic [AW:0]       level,
    output logic              empty,
    output logic              full,
    output logic              idle
);

    logic [1:0]        r_state;
    logic              r_transmit;
    logic [BYTE_W-1:0] r_tx_byte;
    logic [BYTE_W-1:0] w_head;
    logic              w_launch;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (w_launch),
        .flush (flush),
        .rdata (w_head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // A flush in the same cycle suppresses the launch so no stale byte escapes.
    assign w_launch = (r_state == F_IDLE) && !empty && uart_tx_free && !flush;

    assign in_ready      = !full;
    assign uart_transmit = r_transmit;
    assign uart_tx_byte  = r_tx_byte;
    assign idle          = empty && (r_state == F_IDLE) && uart_tx_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= F_IDLE;
            r_transmit <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            case (r_state)
                F_IDLE: begin
                    if (w_launch) begin
                        r_tx_byte  <= w_head;
                        r_transmit <= 1'b1;
                        r_state    <= F_LAUNCH;
                    end
                end
                F_LAUNCH: begin
                    r_transmit <= 1'b0;
                    r_state    <= F_WAIT_BUSY;
                end
                // tx_free is still stale-high here until the UART reacts.
                F_WAIT_BUSY: begin
                    if (!uart_tx_free) begin
                        r_state <= F_WAIT_FREE;
                    end
                end
                F_WAIT_FREE: begin
                    if (uart_tx_free) begin
                        r_state <= F_IDLE;
                    end
                end
                default: begin
                    r_transmit <= 1'b0;
                    r_state    <= F_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_feeder                                               |
// | Purpose  : Directed self-checking bench with a simple UART timing model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic          uart_transmit;
    logic [7:0]    uart_tx_byte;
    logic          uart_tx_free = 1'b1;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          idle;

    int errors = 0;
    int checks = 0;

    // UART model controls
    int   byte_time = 5;
    logic manual = 1'b0;
    logic manual_val = 1'b1;
    logic pending = 1'b0;
    int   busy_cnt = 0;

    // Pulse capture
    int         pulses = 0;
    logic [7:0] seen [0:255];

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .uart_transmit (uart_transmit),
        .uart_tx_byte  (uart_tx_byte),
        .uart_tx_free  (uart_tx_free),
        .level         (level),
        .empty         (empty),
        .full          (full),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (uart_transmit) begin
            seen[pulses[7:0]] <= uart_tx_byte;
            pulses            <= pulses + 1;
        end
    end

    // UART samples transmit, drops tx_free one cycle later, frees after byte_time.
    always @(posedge clk) begin
        if (manual) begin
            uart_tx_free <= manual_val;
            pending      <= 1'b0;
        end else if (uart_transmit) begin
            pending <= 1'b1;
        end else if (pending) begin
            pending      <= 1'b0;
            uart_tx_free <= 1'b0;
            busy_cnt     <= byte_time;
        end else if (!uart_tx_free) begin
            if (busy_cnt <= 1) uart_tx_free <= 1'b1;
            else               busy_cnt <= busy_cnt - 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (uart_transmit === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s pulse timeout got=none exp=pulse", name); end
    endtask

    task automatic wait_idle(input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s idle timeout got=%b exp=1", name, idle); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (level !== 5'd0)        begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)         begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit got=%b exp=0", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got=%h exp=00", uart_tx_byte); end
        checks++; if (idle !== 1'b1)         begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base;
        base      = pulses;
        byte_time = 5;
        in_data   = 8'hA5;
        in_valid  = 1'b1;
        tick();                                  // E0
        in_valid = 1'b0;
        checks++; if (level !== 5'd1)         begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL single_e0_tx got=%b exp=0", uart_transmit); end
        tick();                                  // E1
        checks++; if (uart_transmit !== 1'b1) begin errors++; $display("FAIL single_e1_tx got=%b exp=1", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'hA5) begin errors++; $display("FAIL single_byte got=%h exp=a5", uart_tx_byte); end
        tick();                                  // E2
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL single_e2_tx got=%b exp=0", uart_transmit); end
        wait_idle(100, "single");
        for (int i = 0; i < 5; i++) tick();
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulses - base); end
        checks++; if (idle !== 1'b1)       begin errors++; $display("FAIL single_idle got=%b exp=1", idle); end
    endtask

    task automatic test_burst();
        int  base;
        int  n;
        bit  saw_full;
        bit  ready_bad;
        bit  stuck;
        base      = pulses;
        byte_time = 40;
        saw_full  = 1'b0;
        ready_bad = 1'b0;
        stuck     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 500) begin
                if (full) saw_full = 1'b1;
                tick();
                n++;
            end
            if (n >= 500) stuck = 1'b1;
            tick();
            if (full) begin
                saw_full = 1'b1;
                if (in_ready) ready_bad = 1'b1;
            end
        end
        in_valid = 1'b0;
        checks++; if (stuck)           begin errors++; $display("FAIL burst_push_timeout got=stuck exp=accepted"); end
        checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL burst_full got=%b exp=1", saw_full); end
        checks++; if (ready_bad)       begin errors++; $display("FAIL burst_ready_when_full got=1 exp=0"); end
        wait_idle(3000, "burst");
        checks++; if (pulses - base !== 20) begin errors++; $display("FAIL burst_pulses got=%0d exp=20", pulses - base); end
        for (int j = 0; j < 20; j++) begin
            checks++;
            if (seen[8'(base + j)] !== 8'(j)) begin
                errors++; $display("FAIL burst_order idx=%0d got=%h exp=%h", j, seen[8'(base + j)], 8'(j));
            end
        end
    endtask

    task automatic test_same_edge();
        int base;
        manual     = 1'b1;
        manual_val = 1'b0;
        tick();
        tick();
        base     = pulses;
        in_data  = 8'h11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (level !== 5'd1)         begin errors++; $display("FAIL same_pre_level got=%0d exp=1", level); end
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL same_pre_tx got=%b exp=0", uart_transmit); end
        manual_val = 1'b1;
        tick();
        in_data  = 8'h22;
        in_valid = 1'b1;
        tick();                                  // push 0x22 while 0x11 launches
        in_valid = 1'b0;
        checks++; if (level !== 5'd1)         begin errors++; $display("FAIL same_level got=%0d exp=1", level); end
        checks++; if (uart_transmit !== 1'b1) begin errors++; $display("FAIL same_tx got=%b exp=1", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'h11) begin errors++; $display("FAIL same_byte0 got=%h exp=11", uart_tx_byte); end
        tick();
        manual_val = 1'b0;
        tick();
        tick();
        manual_val = 1'b1;
        wait_pulse(20, "same_second");
        checks++; if (uart_tx_byte !== 8'h22) begin errors++; $display("FAIL same_byte1 got=%h exp=22", uart_tx_byte); end
        checks++; if (level !== 5'd0)         begin errors++; $display("FAIL same_level_after got=%0d exp=0", level); end
        tick();
        manual_val = 1'b0;
        tick();
        tick();
        manual_val = 1'b1;
        tick();
        tick();
        manual = 1'b0;
        wait_idle(50, "same");
        checks++; if (pulses - base !== 2) begin errors++; $display("FAIL same_pulses got=%0d exp=2", pulses - base); end
    endtask

    task automatic test_slow_uart();
        int  base;
        bit  extra;
        manual     = 1'b1;
        manual_val = 1'b1;
        tick();
        base     = pulses;
        extra    = 1'b0;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_pulse(10, "slow_first");
        checks++; if (uart_tx_byte !== 8'h5A) begin errors++; $display("FAIL slow_byte0 got=%h exp=5a", uart_tx_byte); end
        in_data  = 8'h6B;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (uart_transmit) extra = 1'b1;
        end
        checks++; if (extra)              begin errors++; $display("FAIL slow_double_launch got=1 exp=0"); end
        checks++; if (level !== 5'd1)     begin errors++; $display("FAIL slow_level got=%0d exp=1", level); end
        manual_val = 1'b0;
        tick();
        tick();
        manual_val = 1'b1;
        wait_pulse(10, "slow_second");
        checks++; if (uart_tx_byte !== 8'h6B) begin errors++; $display("FAIL slow_byte1 got=%h exp=6b", uart_tx_byte); end
        tick();
        manual_val = 1'b0;
        tick();
        tick();
        manual_val = 1'b1;
        tick();
        tick();
        manual = 1'b0;
        wait_idle(50, "slow");
        checks++; if (pulses - base !== 2) begin errors++; $display("FAIL slow_pulses got=%0d exp=2", pulses - base); end
    endtask

    task automatic test_flush();
        int base;
        base      = pulses;
        byte_time = 30;
        for (int i = 0; i < 6; i++) begin
            in_data  = 8'(8'h40 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (level !== 5'd5)      begin errors++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL flush_inflight got=%0d exp=1", pulses - base); end
        flush    = 1'b1;
        in_data  = 8'h77;
        in_valid = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (level !== 5'd0)  begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
        wait_idle(200, "flush");
        for (int i = 0; i < 5; i++) tick();
        checks++; if (pulses - base !== 1)    begin errors++; $display("FAIL flush_pulses got=%0d exp=1", pulses - base); end
        checks++; if (seen[8'(base)] !== 8'h40) begin errors++; $display("FAIL flush_byte got=%h exp=40", seen[8'(base)]); end
    endtask

    task automatic test_reset_mid();
        int base;
        int n;
        base      = pulses;
        byte_time = 20;
        for (int i = 0; i < 3; i++) begin
            in_data  = 8'(8'h31 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (uart_tx_free && n < 50) begin
            tick();
            n++;
        end
        checks++; if (n >= 50) begin errors++; $display("FAIL rstmid_busy_timeout got=free exp=busy"); end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (level !== 5'd0)         begin errors++; $display("FAIL rstmid_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1)         begin errors++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
        checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
        checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL rstmid_tx got=%b exp=0", uart_transmit); end
        checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte got=%h exp=00", uart_tx_byte); end
        #1;
        rst_n    = 1'b1;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_pulse(100, "rstmid");
        checks++; if (uart_tx_byte !== 8'h3C) begin errors++; $display("FAIL rstmid_new_byte got=%h exp=3c", uart_tx_byte); end
        wait_idle(200, "rstmid");
        for (int i = 0; i < 5; i++) tick();
        checks++; if (pulses - base !== 2) begin errors++; $display("FAIL rstmid_pulses got=%0d exp=2", pulses - base); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_same_edge();
        test_slow_uart();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
